// File: rtl/ntt_pkg.sv
// Shared constants, types and constant-derived twiddle tables for the iterative NTT core.
// Twiddles and modular inverses are computed at elaboration so only Q/OMEGA/N need editing.
package ntt_pkg;
   localparam int N     = 8;
   localparam int LOGN  = 3;
   localparam int WIDTH = 8;
   localparam int Q     = 17;
   localparam int OMEGA = 2;

   localparam int STAGE_W = $clog2(LOGN);
   localparam int BFLY_W  = LOGN - 1;

   typedef logic [WIDTH-1:0]             coef_t;
   typedef logic [2*WIDTH-1:0]           prod_t;
   typedef logic [WIDTH:0]               sum_t;
   typedef logic [N/2-1:0][WIDTH-1:0]    tw_tab_t;
   typedef coef_t                        coef_arr_t [N];

   typedef enum logic [1:0] {IDLE, COMPUTE, SCALE, DONE} state_t;

   function automatic int mod_inv(input int x);
      int r;
      r = 0;
      for (int i = 1; i < Q; i++) begin
         if ((x * i) % Q == 1) r = i;
      end
      return r;
   endfunction

   function automatic tw_tab_t make_twiddles(input int root);
      tw_tab_t t;
      int      acc;
      acc = 1;
      for (int i = 0; i < N/2; i++) begin
         t[i] = coef_t'(acc);
         acc  = (acc * root) % Q;
      end
      return t;
   endfunction

   localparam int      OMEGA_INV = mod_inv(OMEGA);
   localparam int      N_INV     = mod_inv(N);
   localparam tw_tab_t TW_FWD    = make_twiddles(OMEGA);
   localparam tw_tab_t TW_INV    = make_twiddles(OMEGA_INV);

   localparam coef_t              Q_C        = coef_t'(Q);
   localparam sum_t               Q_S        = sum_t'(Q);
   localparam prod_t              Q_P        = prod_t'(Q);
   localparam prod_t              N_INV_P    = prod_t'(N_INV);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOGN - 1);
   localparam logic [BFLY_W-1:0]  LAST_BFLY  = BFLY_W'(N/2 - 1);
endpackage

// File: rtl/ntt_butterfly.sv
// Combinational Cooley-Tukey butterfly: y_a = a + w*b, y_b = a - w*b, both mod Q.
// Zero latency, no handshake; inputs are assumed already reduced below Q.
module ntt_butterfly
   import ntt_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] w,
   output logic [WIDTH-1:0] y_a,
   output logic [WIDTH-1:0] y_b
);
   coef_t t;
   sum_t  sum;
   sum_t  diff;

   always_comb begin
      t    = coef_t'((prod_t'(w) * prod_t'(b)) % Q_P);
      sum  = {1'b0, a} + {1'b0, t};
      // Adding Q before subtracting keeps the difference non-negative.
      diff = {1'b0, a} + Q_S - {1'b0, t};
      y_a  = coef_t'(sum % Q_S);
      y_b  = coef_t'(diff % Q_S);
   end
endmodule

// File: rtl/ntt_butterfly_core.sv
// In-place radix-2 NTT on a bit-reversed array, one butterfly per cycle; NTT_INVERSE_EN adds inverse + N^-1 scaling.
// out_valid 13 cycles after acceptance (14 inverse); one array in flight, in_ready low until output handshake.
module ntt_butterfly_core
   import ntt_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef NTT_INVERSE_EN
   input  logic             inverse,
`endif
   input  logic [WIDTH-1:0] data_in [N-1:0],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out [N-1:0]
);
   state_t             state_q;
   state_t             state_d;
   coef_arr_t          a_q;
   logic [STAGE_W-1:0] stage_q;
   logic [BFLY_W-1:0]  bfly_q;
   logic [LOGN-1:0]    half;
   logic [LOGN-1:0]    low;
   logic [LOGN-1:0]    idx_j;
   logic [LOGN-1:0]    idx_k;
   logic [BFLY_W-1:0]  tw_idx;
   coef_t              w;
   coef_t              y_j;
   coef_t              y_k;
   logic               last_bfly;
`ifdef NTT_INVERSE_EN
   logic               inv_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign last_bfly = (stage_q == LAST_STAGE) && (bfly_q == LAST_BFLY);

   // Butterfly b of stage s pairs j with j+half; the twiddle exponent is the
   // position within the group, scaled so every stage indexes the same table.
   always_comb begin
      half   = LOGN'(1) << stage_q;
      low    = LOGN'(bfly_q) & (half - 1'b1);
      idx_j  = ((LOGN'(bfly_q) - low) << 1) + low;
      idx_k  = idx_j + half;
      tw_idx = BFLY_W'(low << (LAST_STAGE - stage_q));
   end

`ifdef NTT_INVERSE_EN
   assign w = inv_q ? TW_INV[tw_idx] : TW_FWD[tw_idx];
`else
   assign w = TW_FWD[tw_idx];
`endif

   ntt_butterfly u_bfly (
      .a   (a_q[idx_j]),
      .b   (a_q[idx_k]),
      .w   (w),
      .y_a (y_j),
      .y_b (y_k)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = COMPUTE;
         COMPUTE: if (last_bfly) begin
`ifdef NTT_INVERSE_EN
            state_d = inv_q ? SCALE : DONE;
`else
            state_d = DONE;
`endif
         end
`ifdef NTT_INVERSE_EN
         SCALE:   state_d = DONE;
`endif
         DONE:    if (out_valid && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            a_q[i]      <= '0;
            data_out[i] <= '0;
         end
         out_valid <= 1'b0;
         stage_q   <= '0;
         bfly_q    <= '0;
`ifdef NTT_INVERSE_EN
         inv_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               for (int i = 0; i < N; i++) a_q[i] <= coef_t'(data_in[i] % Q_C);
               stage_q <= '0;
               bfly_q  <= '0;
`ifdef NTT_INVERSE_EN
               inv_q   <= inverse;
`endif
            end
            COMPUTE: begin
               a_q[idx_j] <= y_j;
               a_q[idx_k] <= y_k;
               if (bfly_q == LAST_BFLY) begin
                  bfly_q  <= '0;
                  stage_q <= last_bfly ? '0 : stage_q + 1'b1;
               end else begin
                  bfly_q  <= bfly_q + 1'b1;
               end
            end
`ifdef NTT_INVERSE_EN
            SCALE: begin
               for (int i = 0; i < N; i++) a_q[i] <= coef_t'((prod_t'(a_q[i]) * N_INV_P) % Q_P);
            end
`endif
            // Result is registered one cycle after entering DONE, then frozen until taken.
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  for (int i = 0; i < N; i++) data_out[i] <= a_q[i];
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ntt_butterfly_core.sv
// Scoreboard bench for ntt_butterfly_core: reference is a direct O(N^2) DFT over Z_Q.
module tb_ntt_butterfly_core;
   localparam int N     = 8;
   localparam int LOGN  = 3;
   localparam int W     = 8;
   localparam int Q     = 17;
   localparam int OMEGA = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] data_in  [N-1:0];
   logic [W-1:0] data_out [N-1:0];
`ifdef NTT_INVERSE_EN
   logic         inverse = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [N*W-1:0] exp_q [$];

   ntt_butterfly_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef NTT_INVERSE_EN
      .inverse   (inverse),
`endif
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [N*W-1:0] pack_out();
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = data_out[i];
      return r;
   endfunction

   task automatic set_in(input logic [N*W-1:0] v);
      for (int i = 0; i < N; i++) data_in[i] = v[i*W +: W];
   endtask

   function automatic int pow_mod(input int b, input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = (r * b) % Q;
      return r;
   endfunction

   function automatic int inv_mod(input int x);
      int r = 0;
      for (int i = 1; i < Q; i++) if ((x * i) % Q == 1) r = i;
      return r;
   endfunction

   function automatic int bitrev(input int n);
      int r = 0;
      for (int b = 0; b < LOGN; b++) if ((n >> b) & 1) r |= 1 << (LOGN - 1 - b);
      return r;
   endfunction

   // Reorders a natural-order array into the bit-reversed layout the core expects.
   function automatic logic [N*W-1:0] brev_perm(input logic [N*W-1:0] v);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = v[bitrev(i)*W +: W];
      return r;
   endfunction

   // X[k] = sum_n x[n] * root^(n*k) mod Q, x taken from the bit-reversed input.
   function automatic logic [N*W-1:0] ref_ntt(input logic [N*W-1:0] din, input bit inv);
      int x [N];
      int root;
      int acc;
      logic [N*W-1:0] res = '0;
      root = inv ? inv_mod(OMEGA) : OMEGA;
      for (int n = 0; n < N; n++) x[n] = int'(din[bitrev(n)*W +: W]) % Q;
      for (int k = 0; k < N; k++) begin
         acc = 0;
         for (int n = 0; n < N; n++) acc = (acc + x[n] * pow_mod(root, (n * k) % N)) % Q;
         if (inv) acc = (acc * inv_mod(N)) % Q;
         res[k*W +: W] = acc[W-1:0];
      end
      return res;
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", pack_out(), '0);
         end else begin
            logic [N*W-1:0] e;
            e = exp_q.pop_front();
            chk("data_out", pack_out(), e);
            for (int i = 0; i < N; i++) chk("out_below_q", 64'(data_out[i] < Q), 64'd1);
         end
      end
   end

   task automatic run_txn(input logic [N*W-1:0] v, input bit inv, input int hold,
                          input logic [N*W-1:0] exp_v);
      int lat;
      int waitc;
      bit bad;
      logic [N*W-1:0] snap;
      waitc = 0;
      while (!in_ready && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("in_ready_before_send", 64'(in_ready), 64'd1);
      set_in(v);
`ifdef NTT_INVERSE_EN
      inverse = inv;
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(exp_v);
      in_valid = 1'b0;
      lat = 0;
      bad = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = c;
            break;
         end
         if (in_ready) bad = 1'b1;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         set_in({$urandom, $urandom});
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("latency", 64'(lat), inv ? 64'd14 : 64'd13);
      chk("busy_in_ready_low", 64'(bad), 64'd0);
      snap = pack_out();
      bad  = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         if (pack_out() !== snap || in_ready || !out_valid) bad = 1'b1;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid_ready", {62'd0, out_valid, in_ready}, 64'd1);
   endtask

   initial begin
      logic [N*W-1:0] v;
      bit inv;
      bit bad;
      set_in('0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_data_out", pack_out(), 64'd0);
      rst = 1'b0;

      run_txn(64'h1, 1'b0, 0, {8{8'h01}});
      run_txn({8{8'h01}}, 1'b0, 0, 64'h8);
      run_txn(64'h1 << 32, 1'b0, 5, 64'h090D0F1008040201);
      run_txn(64'd20, 1'b0, 1, {8{8'h03}});
      run_txn(64'hFF, 1'b0, 0, 64'h0);

      // Reset after six butterflies: the partial result must never surface.
      set_in(64'h5);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      bad = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) bad = 1'b1;
      end
      chk("rst_no_stale_output", 64'(bad), 64'd0);
      run_txn(64'h1, 1'b0, 2, {8{8'h01}});

      // Reset while a result is waiting in DONE.
      set_in(64'h7);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 40 && !out_valid; c++) begin
         @(posedge clk); #1;
      end
      chk("done_reached", 64'(out_valid), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_done_out_valid", 64'(out_valid), 64'd0);
      chk("rst_done_in_ready", 64'(in_ready), 64'd1);
      chk("rst_done_data_out", pack_out(), 64'd0);

`ifdef NTT_INVERSE_EN
      v = 64'h090D0F1008040201;
      run_txn(v, 1'b1, 1, ref_ntt(v, 1'b1));
      run_txn(64'd20, 1'b1, 0, ref_ntt(64'd20, 1'b1));
      // Round trip: inverse of the forward result recovers the natural-order input.
      v = 64'h0B03100700050C02;
      run_txn(brev_perm(ref_ntt(brev_perm(v), 1'b0)), 1'b1, 0, v);
`endif

      for (int r = 0; r < 30; r++) begin
         v = {$urandom, $urandom};
`ifdef NTT_INVERSE_EN
         inv = 1'($urandom_range(0, 1));
`else
         inv = 1'b0;
`endif
         run_txn(v, inv, int'($urandom_range(0, 3)), ref_ntt(v, inv));
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
